// File: rtl/nibble_exec_core_if.sv
// Instruction handshake bundle for nibble_exec_core.
// Master drives instr/instr_valid, core answers with instr_ready.
interface nibble_exec_core_if #(
  parameter int INSTR_W = 11
) ();
  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic               instr_ready;

  modport master (
    output instr,
    output instr_valid,
    input  instr_ready
  );

  modport slave (
    input  instr,
    input  instr_valid,
    output instr_ready
  );
endinterface

// File: rtl/nibble_exec_core.sv
// Two-stage decode/execute accumulator core.
// Register 0 is the accumulator; carry records add/sub overflow.
module nibble_exec_core #(
  parameter  int DATA_W   = 4,
  parameter  int NUM_REGS = 8,
  localparam int REG_AW   = $clog2(NUM_REGS),
  localparam int INSTR_W  = 4 + REG_AW + DATA_W
) (
  input  logic               clk,
  input  logic               rst_n,
  nibble_exec_core_if.slave  bus,
  input  logic               hold,
  input  logic [REG_AW-1:0]  dbg_addr,
  output logic [DATA_W-1:0]  dbg_data,
  output logic [DATA_W-1:0]  acc_out,
  output logic               carry,
  output logic [15:0]        op_onehot,
  output logic               illegal_op
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] opnd;
  } de_t;

  de_t               de_q;
  logic [DATA_W-1:0] rf [NUM_REGS];

  logic              xfer;
  logic [3:0]        d_op;
  logic [REG_AW-1:0] d_rd;
  logic [DATA_W-1:0] d_opnd;

  logic [REG_AW-1:0] rs;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   diff;
  logic              cin;

  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              c_en;
  logic              c_nxt;

  assign bus.instr_ready = rst_n & ~hold;
  assign xfer   = bus.instr_valid & bus.instr_ready;
  assign d_op   = bus.instr[INSTR_W-1 -: 4];
  assign d_rd   = bus.instr[DATA_W +: REG_AW];
  assign d_opnd = bus.instr[DATA_W-1:0];

  assign dbg_data = rf[dbg_addr];
  assign acc_out  = rf[0];

  assign rs   = de_q.opnd[REG_AW-1:0];
  assign a    = rf[de_q.rd];
  assign b    = rf[rs];
  assign cin  = op_onehot[2] & carry;
  assign sum  = {1'b0, a} + {1'b0, b}
              + {{DATA_W{1'b0}}, cin};
  assign diff = {1'b0, a} - {1'b0, b};

  // Execute: pick writeback value and carry update for E-stage op
  always_comb begin
    wr_en   = 1'b0;
    wr_data = '0;
    c_en    = 1'b0;
    c_nxt   = 1'b0;
    unique case (1'b1)
      op_onehot[1], op_onehot[2]: begin
        wr_en   = 1'b1;
        wr_data = sum[DATA_W-1:0];
        c_en    = 1'b1;
        c_nxt   = sum[DATA_W];
      end
      op_onehot[3]: begin
        wr_en   = 1'b1;
        wr_data = b;
      end
      op_onehot[4]: begin
        wr_en   = 1'b1;
        wr_data = de_q.opnd;
      end
      op_onehot[5]: begin
        wr_en   = 1'b1;
        wr_data = diff[DATA_W-1:0];
        c_en    = 1'b1;
        c_nxt   = diff[DATA_W];
      end
      op_onehot[6]: begin
        wr_en   = 1'b1;
        wr_data = a & b;
      end
      op_onehot[7]: begin
        wr_en   = 1'b1;
        wr_data = a | b;
      end
      op_onehot[8]: begin
        wr_en   = 1'b1;
        wr_data = a ^ b;
      end
      op_onehot[9]: begin
        c_en  = 1'b1;
        c_nxt = 1'b0;
      end
      default: ;
    endcase
  end

  // Pipeline advance: writeback from E, load D from handshake
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++)
        rf[i] <= '0;
      carry      <= 1'b0;
      op_onehot  <= '0;
      illegal_op <= 1'b0;
      de_q       <= '0;
    end else if (!hold) begin
      if (de_q.valid && wr_en)
        rf[de_q.rd] <= wr_data;
      if (de_q.valid && c_en)
        carry <= c_nxt;
      if (xfer) begin
        de_q <= '{valid: 1'b1,
                  rd:    d_rd,
                  opnd:  d_opnd};
        op_onehot  <= 16'(1) << d_op;
        illegal_op <= (d_op >= 4'hA);
      end else begin
        de_q       <= '0;
        op_onehot  <= '0;
        illegal_op <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_nibble_exec_core.sv
// Self-checking bench for nibble_exec_core (DATA_W=4, NUM_REGS=8).
// Directed scenarios then randomized traffic against a reference model.
module tb_nibble_exec_core;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hold;
  logic [2:0]  dbg_addr;
  logic [3:0]  dbg_data;
  logic [3:0]  acc_out;
  logic        carry;
  logic [15:0] op_onehot;
  logic        illegal_op;

  int tests = 0;
  int fails = 0;

  logic [3:0]  m_regs [8];
  logic        m_c;
  bit          pv;
  logic [10:0] pi;

  always #5 clk = ~clk;

  nibble_exec_core_if #(.INSTR_W(11)) bus ();

  nibble_exec_core #(
    .DATA_W   (4),
    .NUM_REGS (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .hold       (hold),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data),
    .acc_out    (acc_out),
    .carry      (carry),
    .op_onehot  (op_onehot),
    .illegal_op (illegal_op)
  );

  function automatic logic [10:0] mk(int op, int rd, int o);
    return {4'(op), 3'(rd), 4'(o)};
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = 4'h0;
    m_c = 1'b0;
    pv  = 1'b0;
    pi  = '0;
  endfunction

  function automatic void m_exec(logic [10:0] w);
    int op, rd, o, rs, a, b, s;
    op = int'(w[10:7]);
    rd = int'(w[6:4]);
    o  = int'(w[3:0]);
    rs = o % 8;
    a  = int'(m_regs[rd]);
    b  = int'(m_regs[rs]);
    case (op)
      1: begin
        s = a + b;
        m_regs[rd] = 4'(s % 16);
        m_c = (s > 15);
      end
      2: begin
        s = a + b + int'(m_c);
        m_regs[rd] = 4'(s % 16);
        m_c = (s > 15);
      end
      3: m_regs[rd] = 4'(b);
      4: m_regs[rd] = 4'(o);
      5: begin
        m_c = (a < b);
        m_regs[rd] = 4'((a - b + 16) % 16);
      end
      6: m_regs[rd] = 4'(a & b);
      7: m_regs[rd] = 4'(a | b);
      8: m_regs[rd] = 4'(a ^ b);
      9: m_c = 1'b0;
      default: ;
    endcase
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic full(string tag);
    logic [15:0] eoh;
    eoh = pv ? (16'(1) << pi[10:7]) : 16'h0;
    chk({tag, "_acc"}, 32'(acc_out), 32'(m_regs[0]));
    chk({tag, "_carry"}, 32'(carry), 32'(m_c));
    chk({tag, "_onehot"}, 32'(op_onehot), 32'(eoh));
    chk({tag, "_illegal"}, 32'(illegal_op),
        32'(pv && (pi[10:7] >= 4'hA)));
    chk({tag, "_ready"}, 32'(bus.instr_ready),
        32'(rst_n & ~hold));
    chk({tag, "_dbg"}, 32'(dbg_data), 32'(m_regs[dbg_addr]));
  endtask

  // One clock: drive at negedge, update model at the edge, return at negedge
  task automatic cyc(bit v, logic [10:0] w, bit h);
    bus.instr_valid = v;
    bus.instr       = w;
    hold            = h;
    @(posedge clk);
    if (!rst_n) begin
      m_reset();
    end else if (!h) begin
      if (pv) m_exec(pi);
      pv = v;
      pi = w;
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n           = 1'b0;
    hold            = 1'b0;
    dbg_addr        = 3'd0;
    bus.instr_valid = 1'b0;
    bus.instr       = '0;
    m_reset();
    @(negedge clk);
    cyc(0, '0, 0);
    cyc(0, '0, 0);
    full("reset");
    rst_n = 1'b1;

    // back-to-back LDI/LDI/ADD with dependency
    cyc(1, mk(4, 1, 7), 0);
    chk("t3_ldi_onehot", 32'(op_onehot), 32'h0010);
    full("t1_a");
    cyc(1, mk(4, 0, 9), 0);
    full("t1_b");
    cyc(1, mk(1, 0, 1), 0);
    chk("t3_add_onehot", 32'(op_onehot), 32'h0002);
    full("t1_c");
    cyc(0, '0, 0);
    chk("t1_acc", 32'(acc_out), 32'h0);
    chk("t1_carry", 32'(carry), 32'h1);
    chk("t3_idle_onehot", 32'(op_onehot), 32'h0);
    full("t1_d");

    // ADDC consumes carry
    cyc(1, mk(2, 0, 1), 0);
    cyc(0, '0, 0);
    chk("t2_acc", 32'(acc_out), 32'h8);
    chk("t2_carry", 32'(carry), 32'h0);
    full("t2");

    // SUB with borrow, then MOV and debug read
    cyc(1, mk(4, 2, 3), 0);
    cyc(1, mk(5, 2, 1), 0);
    cyc(1, mk(3, 3, 2), 0);
    dbg_addr = 3'd2;
    full("t4_a");
    cyc(0, '0, 0);
    dbg_addr = 3'd3;
    #1;
    chk("t4_r3", 32'(dbg_data), 32'hC);
    chk("t4_carry", 32'(carry), 32'h1);
    full("t4_b");

    // hold freezes ADD in E, valid input ignored meanwhile
    dbg_addr = 3'd0;
    cyc(1, mk(1, 0, 1), 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, mk(4, 0, 0), 1);
      chk("t5_ready", 32'(bus.instr_ready), 32'h0);
      chk("t5_acc", 32'(acc_out), 32'h8);
      chk("t5_carry", 32'(carry), 32'h1);
      full("t5_hold");
    end
    cyc(0, '0, 0);
    chk("t5_exec", 32'(acc_out), 32'hF);
    chk("t5_carry_after", 32'(carry), 32'h0);
    full("t5_after");

    // illegal opcode pulse
    cyc(1, mk(11, 0, 5), 0);
    chk("t6_illegal", 32'(illegal_op), 32'h1);
    chk("t6_onehot", 32'(op_onehot), 32'h0800);
    cyc(0, '0, 0);
    chk("t6_illegal_off", 32'(illegal_op), 32'h0);
    chk("t6_acc", 32'(acc_out), 32'hF);
    full("t6_a");

    // reset while ADD is in E discards it
    cyc(1, mk(1, 0, 1), 0);
    rst_n = 1'b0;
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      cyc(0, '0, 0);
      chk("t6_rst_reg", 32'(dbg_data), 32'h0);
      full("t6_rst");
    end
    rst_n = 1'b1;

    // randomized traffic
    for (int n = 0; n < 500; n++) begin
      rst_n    = ($urandom_range(0, 49) != 0);
      dbg_addr = 3'($urandom);
      cyc($urandom_range(0, 3) != 0, 11'($urandom),
          $urandom_range(0, 6) == 0);
      full("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
